score_display: RTL and testbench

Scoreboard and seven-segment scan driver for the E-Hockey game. It counts goals for both players in BCD and detects the win condition. It drives the board's four-digit multiplexed seven-segment display, refreshing one digit per period of the ~1 kHz scan square wave from the clock divider. Everything runs in the 100 MHz system domain; the scan wave is treated as asynchronous data, never as a clock.

---
 rtl/hockey_pkg.sv | 29 ++
 rtl/seg7_decode.sv | 10 +
 rtl/score_display.sv | 106 ++++++++++
 tb/tb_score_display.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/hockey_pkg.sv
// hockey_pkg: shared seven-segment patterns, winner codes and game state for the E-Hockey scoreboard
package hockey_pkg;
   typedef enum logic {PLAY, OVER} state_t;
   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_P1 = 2'b01;
   localparam logic [1:0] WIN_P2 = 2'b10;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   function automatic logic [6:0] seg_pattern(input logic [3:0] d);
      case (d)
         4'd0: seg_pattern = 7'b1000000;
         4'd1: seg_pattern = 7'b1111001;
         4'd2: seg_pattern = 7'b0100100;
         4'd3: seg_pattern = 7'b0110000;
         4'd4: seg_pattern = 7'b0011001;
         4'd5: seg_pattern = 7'b0010010;
         4'd6: seg_pattern = 7'b0000010;
         4'd7: seg_pattern = 7'b1111000;
         4'd8: seg_pattern = 7'b0000000;
         4'd9: seg_pattern = 7'b0010000;
         default: seg_pattern = SEG_BLANK;
      endcase
   endfunction
   function automatic logic [7:0] bcd_inc(input logic [7:0] s);
      bcd_inc = (s[3:0] == 4'd9) ? {s[7:4] + 4'd1, 4'd0} : {s[7:4], s[3:0] + 4'd1};
   endfunction
   function automatic int bcd_val(input logic [7:0] s);
      bcd_val = int'(s[7:4]) * 10 + int'(s[3:0]);
   endfunction
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: BCD digit plus blank flag to active-low {g,f,e,d,c,b,a} segments
module seg7_decode
   import hockey_pkg::*;
(
   input  logic [3:0] digit,
   input  logic       blank,
   output logic [6:0] seg
);
   assign seg = blank ? SEG_BLANK : seg_pattern(digit);
endmodule

// File: rtl/score_display.sv
// score_display: BCD scoreboard with win detection and a four-digit multiplexed seven-segment scan driver
module score_display
   import hockey_pkg::*;
#(
   parameter int WIN_SCORE = 7
) (
   input  logic       in_clk,
   input  logic       reset,
   input  logic       scan_clk,
   input  logic       goal_p1,
   input  logic       goal_p2,
   input  logic       new_game,
   output logic [6:0] seg,
   output logic [3:0] an,
   output logic       dp,
   output logic [1:0] winner,
   output logic       game_over
);
   logic       s1, s2, s3;
   logic       scan_tick;
   logic [1:0] idx;
   logic [7:0] p1, p2, p1_nxt, p2_nxt;
   logic [1:0] winner_nxt;
   state_t     state, state_nxt;
   logic [3:0] digit;
   logic       blank;
   logic [6:0] dec_seg;

   assign scan_tick = s2 & ~s3;
   assign dp = 1'b1;
   assign game_over = (state == OVER);

   // scan_clk is only data here: synchronise it, step the digit index on its rising edge, register the drive
   always_ff @(posedge in_clk) begin
      if (reset) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
         idx <= 2'd0;
         an <= 4'b1110;
         seg <= 7'b1000000;
      end else begin
         s1 <= scan_clk;
         s2 <= s1;
         s3 <= s2;
         idx <= scan_tick ? idx + 2'd1 : idx;
         an <= ~(4'b0001 << idx);
         seg <= dec_seg;
      end
   end

   // index 0/1 are P2 ones/tens, 2/3 are P1 ones/tens; zero tens digits are blanked
   always_comb begin
      digit = idx[1] ? (idx[0] ? p1[7:4] : p1[3:0]) : (idx[0] ? p2[7:4] : p2[3:0]);
      blank = idx[0] & (digit == 4'd0);
   end

   seg7_decode u_dec (
      .digit(digit),
      .blank(blank),
      .seg  (dec_seg)
   );

   // game state, scores and winner registers
   always_ff @(posedge in_clk) begin
      if (reset) begin
         state <= PLAY;
         p1 <= 8'h00;
         p2 <= 8'h00;
         winner <= WIN_NONE;
      end else begin
         state <= state_nxt;
         p1 <= p1_nxt;
         p2 <= p2_nxt;
         winner <= winner_nxt;
      end
   end

   // new_game beats goals; simultaneous goals cancel; reaching WIN_SCORE ends the game
   always_comb begin
      state_nxt = state;
      p1_nxt = p1;
      p2_nxt = p2;
      winner_nxt = winner;
      if (new_game) begin
         state_nxt = PLAY;
         p1_nxt = 8'h00;
         p2_nxt = 8'h00;
         winner_nxt = WIN_NONE;
      end else if (state == PLAY && (goal_p1 ^ goal_p2)) begin
         if (goal_p1) begin
            p1_nxt = bcd_inc(p1);
            if (bcd_val(p1_nxt) == WIN_SCORE) begin
               state_nxt = OVER;
               winner_nxt = WIN_P1;
            end
         end else begin
            p2_nxt = bcd_inc(p2);
            if (bcd_val(p2_nxt) == WIN_SCORE) begin
               state_nxt = OVER;
               winner_nxt = WIN_P2;
            end
         end
      end
   end
endmodule

// File: tb/tb_score_display.sv
// tb_score_display: directed checks of reset, scan sequencing, scoring, win, new_game and mid-scan reset
module tb_score_display;
   logic       in_clk = 1'b0;
   logic       reset = 1'b1;
   logic       scan_clk = 1'b0;
   logic       goal_p1 = 1'b0;
   logic       goal_p2 = 1'b0;
   logic       new_game = 1'b0;
   logic [6:0] seg;
   logic [3:0] an;
   logic       dp;
   logic [1:0] winner;
   logic       game_over;
   int         checks = 0;
   int         errors = 0;

   localparam logic [6:0] S0 = 7'b1000000;
   localparam logic [6:0] S1 = 7'b1111001;
   localparam logic [6:0] S3 = 7'b0110000;
   localparam logic [6:0] S5 = 7'b0010010;
   localparam logic [6:0] SB = 7'b1111111;

   score_display #(.WIN_SCORE(12)) dut (
      .in_clk   (in_clk),
      .reset    (reset),
      .scan_clk (scan_clk),
      .goal_p1  (goal_p1),
      .goal_p2  (goal_p2),
      .new_game (new_game),
      .seg      (seg),
      .an       (an),
      .dp       (dp),
      .winner   (winner),
      .game_over(game_over)
   );

   always #5 in_clk = ~in_clk;

   task automatic goal(input logic a, input logic b);
      goal_p1 = a;
      goal_p2 = b;
      @(negedge in_clk);
      goal_p1 = 1'b0;
      goal_p2 = 1'b0;
      @(negedge in_clk);
   endtask

   task automatic scan_step();
      scan_clk = 1'b1;
      repeat (4) @(negedge in_clk);
      scan_clk = 1'b0;
      repeat (4) @(negedge in_clk);
   endtask

   task automatic pulse_new_game();
      new_game = 1'b1;
      @(negedge in_clk);
      new_game = 1'b0;
      @(negedge in_clk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge in_clk);
      reset = 1'b0;
      repeat (20) @(negedge in_clk);
      checks++;
      if ({an, seg, dp, winner, game_over} !== {4'b1110, S0, 1'b1, 2'b00, 1'b0}) begin
         errors++;
         $display("FAIL reset_idle an=%b seg=%b dp=%b winner=%b go=%b expected an=1110 seg=1000000 dp=1 winner=00 go=0",
                  an, seg, dp, winner, game_over);
      end
   endtask

   task automatic test_scan();
      logic [3:0] exp_an [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
      logic [6:0] exp_seg [4] = '{SB, S3, SB, S0};
      logic [3:0] prev_an;
      repeat (3) goal(1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         prev_an = an;
         scan_clk = 1'b1;
         repeat (3) @(negedge in_clk);
         checks++;
         if (an !== prev_an) begin
            errors++;
            $display("FAIL scan_early_%0d an=%b expected %b", i, an, prev_an);
         end
         @(negedge in_clk);
         checks++;
         if (an !== exp_an[i] || seg !== exp_seg[i]) begin
            errors++;
            $display("FAIL scan_digit_%0d an=%b seg=%b expected an=%b seg=%b", i, an, seg, exp_an[i], exp_seg[i]);
         end
         repeat (46) @(negedge in_clk);
         scan_clk = 1'b0;
         repeat (50) @(negedge in_clk);
      end
   endtask

   task automatic test_win();
      pulse_new_game();
      repeat (10) goal(1'b0, 1'b1);
      checks++;
      if (an !== 4'b1110 || seg !== S0 || game_over !== 1'b0) begin
         errors++;
         $display("FAIL p2_ones_10 an=%b seg=%b go=%b expected an=1110 seg=%b go=0", an, seg, game_over, S0);
      end
      scan_step();
      checks++;
      if (an !== 4'b1101 || seg !== S1) begin
         errors++;
         $display("FAIL p2_tens_10 an=%b seg=%b expected an=1101 seg=%b", an, seg, S1);
      end
      goal(1'b0, 1'b1);
      goal_p2 = 1'b1;
      @(negedge in_clk);
      goal_p2 = 1'b0;
      checks++;
      if (game_over !== 1'b1 || winner !== 2'b10) begin
         errors++;
         $display("FAIL win_p2 go=%b winner=%b expected go=1 winner=10", game_over, winner);
      end
      @(negedge in_clk);
      scan_step();
      goal(1'b1, 1'b0);
      checks++;
      if (an !== 4'b1011 || seg !== S0 || game_over !== 1'b1 || winner !== 2'b10) begin
         errors++;
         $display("FAIL over_ignores an=%b seg=%b go=%b winner=%b expected an=1011 seg=%b go=1 winner=10",
                  an, seg, game_over, winner, S0);
      end
   endtask

   task automatic test_new_game();
      goal_p1 = 1'b1;
      new_game = 1'b1;
      @(negedge in_clk);
      goal_p1 = 1'b0;
      new_game = 1'b0;
      checks++;
      if (game_over !== 1'b0 || winner !== 2'b00) begin
         errors++;
         $display("FAIL new_game_clear go=%b winner=%b expected go=0 winner=00", game_over, winner);
      end
      @(negedge in_clk);
      checks++;
      if (an !== 4'b1011 || seg !== S0) begin
         errors++;
         $display("FAIL new_game_p1 an=%b seg=%b expected an=1011 seg=%b", an, seg, S0);
      end
   endtask

   task automatic test_simultaneous();
      goal(1'b1, 1'b1);
      checks++;
      if (seg !== S0) begin
         errors++;
         $display("FAIL both_goals seg=%b expected %b", seg, S0);
      end
      goal(1'b1, 1'b0);
      checks++;
      if (seg !== S1) begin
         errors++;
         $display("FAIL lone_p1 seg=%b expected %b", seg, S1);
      end
      scan_step();
      scan_step();
      checks++;
      if (an !== 4'b1110 || seg !== S0) begin
         errors++;
         $display("FAIL both_p2_zero an=%b seg=%b expected an=1110 seg=%b", an, seg, S0);
      end
   endtask

   task automatic test_reset_mid();
      pulse_new_game();
      repeat (5) goal(1'b1, 1'b0);
      repeat (4) goal(1'b0, 1'b1);
      checks++;
      if (seg !== 7'b0011001) begin
         errors++;
         $display("FAIL p2_four seg=%b expected 0011001", seg);
      end
      scan_step();
      scan_step();
      checks++;
      if (an !== 4'b1011 || seg !== S5) begin
         errors++;
         $display("FAIL p1_five an=%b seg=%b expected an=1011 seg=%b", an, seg, S5);
      end
      scan_clk = 1'b1;
      repeat (2) @(negedge in_clk);
      reset = 1'b1;
      @(negedge in_clk);
      reset = 1'b0;
      checks++;
      if ({an, seg, dp, winner, game_over} !== {4'b1110, S0, 1'b1, 2'b00, 1'b0}) begin
         errors++;
         $display("FAIL reset_mid an=%b seg=%b dp=%b winner=%b go=%b expected an=1110 seg=1000000 dp=1 winner=00 go=0",
                  an, seg, dp, winner, game_over);
      end
      scan_clk = 1'b0;
      repeat (4) @(negedge in_clk);
      scan_step();
      scan_step();
      checks++;
      if (an !== 4'b1011 || seg !== S0) begin
         errors++;
         $display("FAIL reset_mid_p1 an=%b seg=%b expected an=1011 seg=%b", an, seg, S0);
      end
   endtask

   initial begin
      @(negedge in_clk);
      test_reset();
      test_scan();
      test_win();
      test_new_game();
      test_simultaneous();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
